// File: rtl/vga_bcd_pkg.sv
// rtl/vga_bcd_pkg.sv - shared BCD digit type, limit constants and clamp helper
//
// Purpose : common definitions for the BCD event counter in the VGA display path.
// Contents: bcd_t     - one packed BCD digit
//           BCD_MAX   - largest legal digit value (9)
//           BCD_ZERO  - smallest digit value (0)
//           bcd_clamp - maps any 4-bit value above 9 down to 9

package vga_bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  function automatic bcd_t bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_event_counter_if.sv
// rtl/bcd_event_counter_if.sv - control/readout bundle for bcd_event_counter
//
// Purpose : groups the strobe, load and readout signals of the counter.
// Signals : d_inc, d_dec - increment/decrement strobes (counted on rising edge)
//           d_clr        - synchronous clear, level-sensitive
//           ld_en        - parallel load enable, level-sensitive
//           ld_val       - load value, digit k in bits [4k+3:4k]
//           digits       - current count, same packing as ld_val
//           ovf, unf     - one-cycle limit pulses
//           at_max       - all digits are 9
//           at_zero      - all digits are 0
// Modports: master drives the controls, slave is the counter.

interface bcd_event_counter_if #(
  parameter int NDIG = 3
);

  logic                d_inc;
  logic                d_dec;
  logic                d_clr;
  logic                ld_en;
  logic [4*NDIG-1:0]   ld_val;
  logic [4*NDIG-1:0]   digits;
  logic                ovf;
  logic                unf;
  logic                at_max;
  logic                at_zero;

  modport master (
    output d_inc, d_dec, d_clr, ld_en, ld_val,
    input  digits, ovf, unf, at_max, at_zero
  );

  modport slave (
    input  d_inc, d_dec, d_clr, ld_en, ld_val,
    output digits, ovf, unf, at_max, at_zero
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit of the ripple carry/borrow chain
//
// Purpose : computes the next value of a single digit for a +1 or -1 step.
// Ports   : digit_i - current digit
//           cin     - carry in (increment this digit)
//           bin     - borrow in (decrement this digit)
//           digit_o - next digit value
//           cout    - carry out, digit is 9 and cin
//           bout    - borrow out, digit is 0 and bin
// cin and bin are never both driven high by the counter.

module bcd_digit_cell
  import vga_bcd_pkg::*;
(
  input  bcd_t digit_i,
  input  logic cin,
  input  logic bin,
  output bcd_t digit_o,
  output logic cout,
  output logic bout
);

  bcd_t digit_v;

  // Clamp keeps the arithmetic inside 0..9 even for an illegal input value.
  assign digit_v = bcd_clamp(digit_i);

  always_comb begin
    digit_o = digit_v;
    if (cin) begin
      digit_o = (digit_v == BCD_MAX) ? BCD_ZERO : digit_v + 4'd1;
    end else if (bin) begin
      digit_o = (digit_v == BCD_ZERO) ? BCD_MAX : digit_v - 4'd1;
    end
  end

  assign cout = cin & (digit_v == BCD_MAX);
  assign bout = bin & (digit_v == BCD_ZERO);

endmodule

// File: rtl/bcd_event_counter.sv
// rtl/bcd_event_counter.sv - N-digit BCD up/down event counter with wrap/saturate
//
// Purpose : counts rising edges of d_inc/d_dec in BCD for score/timer readouts.
// Params  : NDIG     - number of BCD digits (1..8)
//           SATURATE - 0 wraps at the limits, 1 holds at the limits
// Ports   : clk   - system clock, all state on rising edge
//           reset - synchronous, active-low
//           bus   - slave side of bcd_event_counter_if (controls and readout)
// Priority: reset > clear > load > (inc & dec edge) > inc edge > dec edge > hold.

module bcd_event_counter
  import vga_bcd_pkg::*;
#(
  parameter int NDIG     = 3,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_event_counter_if.slave    bus
);

  logic [4*NDIG-1:0] digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;

  logic              inc_ev, dec_ev;
  logic              do_inc, do_dec;
  logic [4*NDIG-1:0] chain_next;
  logic [NDIG:0]     carry;
  logic [NDIG:0]     borrow;
  logic              at_max, at_zero;

  assign inc_ev = bus.d_inc & ~inc_q;
  assign dec_ev = bus.d_dec & ~dec_q;

  // Simultaneous edges cancel, so the chain only ever runs one direction.
  assign do_inc = inc_ev & ~dec_ev;
  assign do_dec = dec_ev & ~inc_ev;

  assign carry[0]  = do_inc;
  assign borrow[0] = do_dec;

  for (genvar k = 0; k < NDIG; k++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit_i (digits_q[4*k +: 4]),
      .cin     (carry[k]),
      .bin     (borrow[k]),
      .digit_o (chain_next[4*k +: 4]),
      .cout    (carry[k+1]),
      .bout    (borrow[k+1])
    );
  end

  always_comb begin
    at_max  = 1'b1;
    at_zero = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (digits_q[4*k +: 4] != BCD_MAX)  at_max  = 1'b0;
      if (digits_q[4*k +: 4] != BCD_ZERO) at_zero = 1'b0;
    end
  end

  // Carry/borrow out of the top digit means the step hit a range limit:
  // the chain already yields the wrapped value, saturation just blocks the write.
  always_comb begin
    digits_d = digits_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inc_d    = bus.d_inc;
    dec_d    = bus.d_dec;
    if (bus.d_clr) begin
      digits_d = '0;
    end else if (bus.ld_en) begin
      for (int k = 0; k < NDIG; k++) begin
        digits_d[4*k +: 4] = bcd_clamp(bus.ld_val[4*k +: 4]);
      end
    end else if (do_inc || do_dec) begin
      ovf_d = carry[NDIG];
      unf_d = borrow[NDIG];
      if (!((SATURATE != 0) && (carry[NDIG] || borrow[NDIG]))) begin
        digits_d = chain_next;
      end
    end
  end

  // Edge registers reset high so a strobe already asserted at release is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inc_q    <= 1'b1;
      dec_q    <= 1'b1;
    end else begin
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.at_max  = at_max;
  assign bus.at_zero = at_zero;

endmodule

// File: tb/tb_bcd_event_counter.sv
// tb/tb_bcd_event_counter.sv - self-checking bench for bcd_event_counter

module tb_bcd_event_counter;

  logic        clk;
  logic        reset;
  logic        d_inc, d_dec, d_clr, ld_en;
  logic [31:0] ld_val;

  int checks;
  int failures;

  bcd_event_counter_if #(.NDIG(3)) if_w ();
  bcd_event_counter_if #(.NDIG(3)) if_s ();
  bcd_event_counter_if #(.NDIG(1)) if_1 ();
  bcd_event_counter_if #(.NDIG(8)) if_8 ();

  assign if_w.d_inc = d_inc;  assign if_w.d_dec = d_dec;
  assign if_w.d_clr = d_clr;  assign if_w.ld_en = ld_en;
  assign if_w.ld_val = ld_val[11:0];
  assign if_s.d_inc = d_inc;  assign if_s.d_dec = d_dec;
  assign if_s.d_clr = d_clr;  assign if_s.ld_en = ld_en;
  assign if_s.ld_val = ld_val[11:0];
  assign if_1.d_inc = d_inc;  assign if_1.d_dec = d_dec;
  assign if_1.d_clr = d_clr;  assign if_1.ld_en = ld_en;
  assign if_1.ld_val = ld_val[3:0];
  assign if_8.d_inc = d_inc;  assign if_8.d_dec = d_dec;
  assign if_8.d_clr = d_clr;  assign if_8.ld_en = ld_en;
  assign if_8.ld_val = ld_val;

  bcd_event_counter #(.NDIG(3), .SATURATE(0)) u_wrap (.clk(clk), .reset(reset), .bus(if_w));
  bcd_event_counter #(.NDIG(3), .SATURATE(1)) u_sat  (.clk(clk), .reset(reset), .bus(if_s));
  bcd_event_counter #(.NDIG(1), .SATURATE(0)) u_one  (.clk(clk), .reset(reset), .bus(if_1));
  bcd_event_counter #(.NDIG(8), .SATURATE(0)) u_eight(.clk(clk), .reset(reset), .bus(if_8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          clr, ld, inc, dec;
    logic [11:0] ldv;
    logic [11:0] ew;
    bit          ewo, ewu;
    logic [11:0] es;
    bit          eso, esu;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //            clr   ld    inc   dec   ld_val   wrap digits/ovf/unf   sat digits/ovf/unf
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h099, 12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h999, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h999, 1'b0, 1'b1, 12'h998, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h999, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h999, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 12'h999, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h002, 1'b0, 1'b0, 12'h999, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h999, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h999, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h456, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h5C0, 12'h590, 1'b0, 1'b0, 12'h590, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h500, 12'h500, 1'b0, 1'b0, 12'h500, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h500, 1'b0, 1'b0, 12'h500, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h500, 1'b0, 1'b0, 12'h500, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h500, 1'b0, 1'b0, 12'h500, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h500, 1'b0, 1'b0, 12'h500, 1'b0, 1'b0};
    vecs[28] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'hFAF, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0};

    // Reset with the increment strobe already high.
    reset = 1'b0;
    d_inc = 1'b1;
    d_dec = 1'b0;
    d_clr = 1'b0;
    ld_en = 1'b0;
    ld_val = '0;
    step();
    step();
    chk("rst_w_digits",  32'(if_w.digits), 32'h0);
    chk("rst_w_ovf",     32'(if_w.ovf), 32'h0);
    chk("rst_w_unf",     32'(if_w.unf), 32'h0);
    chk("rst_w_at_zero", 32'(if_w.at_zero), 32'h1);
    chk("rst_w_at_max",  32'(if_w.at_max), 32'h0);
    chk("rst_8_digits",  if_8.digits, 32'h0);

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("held_inc_%0d", i), 32'(if_w.digits), 32'h0);
    end
    d_inc = 1'b0;
    step();
    chk("inc_low", 32'(if_w.digits), 32'h0);
    d_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("inc_high_%0d_digits", i), 32'(if_w.digits), 32'h001);
      chk($sformatf("inc_high_%0d_ovf", i), 32'(if_w.ovf), 32'h0);
    end

    for (int i = 0; i < 29; i++) begin
      d_clr  = vecs[i].clr;
      ld_en  = vecs[i].ld;
      d_inc  = vecs[i].inc;
      d_dec  = vecs[i].dec;
      ld_val = 32'(vecs[i].ldv);
      step();
      chk($sformatf("v%0d_w_digits", i), 32'(if_w.digits), 32'(vecs[i].ew));
      chk($sformatf("v%0d_w_ovf", i), 32'(if_w.ovf), 32'(vecs[i].ewo));
      chk($sformatf("v%0d_w_unf", i), 32'(if_w.unf), 32'(vecs[i].ewu));
      chk($sformatf("v%0d_w_at_max", i), 32'(if_w.at_max), 32'(vecs[i].ew == 12'h999));
      chk($sformatf("v%0d_w_at_zero", i), 32'(if_w.at_zero), 32'(vecs[i].ew == 12'h000));
      chk($sformatf("v%0d_s_digits", i), 32'(if_s.digits), 32'(vecs[i].es));
      chk($sformatf("v%0d_s_ovf", i), 32'(if_s.ovf), 32'(vecs[i].eso));
      chk($sformatf("v%0d_s_unf", i), 32'(if_s.unf), 32'(vecs[i].esu));
    end

    // NDIG=1 and NDIG=8 limits.
    d_clr = 1'b0; d_inc = 1'b0; d_dec = 1'b0;
    ld_en = 1'b1; ld_val = 32'h99999999;
    step();
    chk("n1_load", 32'(if_1.digits), 32'h9);
    chk("n8_load", if_8.digits, 32'h99999999);
    chk("n8_at_max", 32'(if_8.at_max), 32'h1);
    ld_en = 1'b0; d_inc = 1'b1;
    step();
    chk("n1_wrap", 32'(if_1.digits), 32'h0);
    chk("n1_ovf", 32'(if_1.ovf), 32'h1);
    chk("n8_wrap", if_8.digits, 32'h0);
    chk("n8_ovf", 32'(if_8.ovf), 32'h1);
    chk("n8_at_zero", 32'(if_8.at_zero), 32'h1);
    chk("n8_at_max_off", 32'(if_8.at_max), 32'h0);
    d_inc = 1'b0;
    step();
    chk("n1_ovf_end", 32'(if_1.ovf), 32'h0);
    chk("n8_ovf_end", 32'(if_8.ovf), 32'h0);
    d_dec = 1'b1;
    step();
    chk("n1_unf_wrap", 32'(if_1.digits), 32'h9);
    chk("n1_unf", 32'(if_1.unf), 32'h1);
    chk("n8_unf_wrap", if_8.digits, 32'h99999999);
    chk("n8_unf", 32'(if_8.unf), 32'h1);
    d_dec = 1'b0; ld_en = 1'b1; ld_val = 32'h00999999;
    step();
    chk("n8_load2", if_8.digits, 32'h00999999);
    ld_en = 1'b0; d_inc = 1'b1;
    step();
    chk("n8_ripple", if_8.digits, 32'h01000000);
    chk("n8_ripple_ovf", 32'(if_8.ovf), 32'h0);

    // Reset mid-count beats a fresh increment edge.
    d_inc = 1'b0;
    step();
    d_inc = 1'b1; reset = 1'b0;
    step();
    chk("midrst_n8", if_8.digits, 32'h0);
    chk("midrst_n8_ovf", 32'(if_8.ovf), 32'h0);
    reset = 1'b1;
    step();
    chk("midrst_release_held", if_8.digits, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
